// File: rtl/seq_monitor.sv
// -----------------------------------------------------------------------------
// seq_monitor
//
// Purpose:
//   Checker placed directly after a 4-bit wrapping down-counter (HI..LO, one
//   step per CE). It confirms that every counter step follows the legal order
//   HI, HI-1, ..., LO, HI, ...
//   It reports lock status, one-cycle error pulses, a saturating error count
//   and a count of completed laps.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous reset, active-low
//   CE          in   count enable, same signal that steps the upstream counter
//   CLR         in   synchronous clear of counters and state
//   VAL[3:0]    in   upstream counter value
//   LOCK        out  high while tracking a valid sequence
//   ERR         out  one-cycle pulse per sequence violation
//   ERR_CNT     out  saturating violation count (ERR_W bits)
//   LAP_CNT     out  wrapping count of LO->HI wraps seen while locked (LAP_W bits)
//   ERR_STICKY  out  only with SEQ_MONITOR_STICKY_EN: set with ERR, cleared by
//                    CLR or RST
//
// Handshake:
//   There is no ready/valid pair. CE is a one-way strobe and cannot be
//   back-pressured. The upstream counter updates VAL on the edge where CE=1.
//   A one-cycle delayed copy of CE therefore marks the cycle in which VAL
//   holds the new value (the sample cycle).
//   All outputs are registered. A CE edge at cycle n is sampled in cycle n+1
//   and shows on the outputs in cycle n+2.
//
// Optional feature macro: SEQ_MONITOR_STICKY_EN
// -----------------------------------------------------------------------------
module seq_monitor #(
    parameter int LO    = 5,
    parameter int HI    = 14,
    parameter int ERR_W = 8,
    parameter int LAP_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             CLR,
    input  logic [3:0]       VAL,
    output logic             LOCK,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [LAP_W-1:0] LAP_CNT
`ifdef SEQ_MONITOR_STICKY_EN
    ,
    output logic             ERR_STICKY
`endif
);

    localparam logic [3:0] LO_V = 4'(LO);
    localparam logic [3:0] HI_V = 4'(HI);

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         prev_q, prev_d;
    logic               ce_d_q;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [LAP_W-1:0]   lap_cnt_q, lap_cnt_d;

    logic               in_range;
    logic [3:0]         exp_val;
    logic               step_ok;

    assign in_range = (VAL >= LO_V) && (VAL <= HI_V);
    // Successor of the previous value: LO wraps back to HI.
    assign exp_val  = (prev_q == LO_V) ? HI_V : (prev_q - 4'd1);
    // A stalled counter (VAL == prev) never equals exp_val, so it counts as an error.
    assign step_ok  = (VAL == exp_val);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        lap_cnt_d = lap_cnt_q;
        if (ce_d_q) begin
            case (state_q)
                SYNC: begin
                    // Values outside the legal range are ignored while unlocked.
                    if (in_range) begin
                        state_d = TRACK;
                        prev_d  = VAL;
                    end
                end
                TRACK: begin
                    if (step_ok) begin
                        prev_d = VAL;
                        if (prev_q == LO_V) begin
                            lap_cnt_d = lap_cnt_q + LAP_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        // An in-range value resyncs immediately.
                        // Anything else drops back to SYNC.
                        if (in_range) begin
                            prev_d = VAL;
                        end else begin
                            state_d = SYNC;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

`ifdef SEQ_MONITOR_STICKY_EN
    logic sticky_q;
    assign ERR_STICKY = sticky_q;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= SYNC;
            prev_q    <= 4'd0;
            ce_d_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            lap_cnt_q <= '0;
`ifdef SEQ_MONITOR_STICKY_EN
            sticky_q  <= 1'b0;
`endif
        end else if (CLR) begin
            // A sample that coincides with CLR is dropped: none of the _d values is used.
            state_q   <= SYNC;
            prev_q    <= 4'd0;
            ce_d_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            lap_cnt_q <= '0;
`ifdef SEQ_MONITOR_STICKY_EN
            sticky_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            ce_d_q    <= CE;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            lap_cnt_q <= lap_cnt_d;
`ifdef SEQ_MONITOR_STICKY_EN
            sticky_q  <= sticky_q | err_d;
`endif
        end
    end

    // The state register is a single bit, so LOCK is a register output.
    assign LOCK    = (state_q == TRACK);
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;
    assign LAP_CNT = lap_cnt_q;

endmodule

// File: tb/tb_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_seq_monitor
//
// Drives two seq_monitor instances with the same stimulus: dut_a has
// ERR_W=8 and dut_b has ERR_W=2. The bench emulates the upstream counter:
// VAL changes in the cycle after each CE. Each cycle is checked against a
// reference model that works on plain integers. Directed scenarios come first,
// then a randomized phase.
// -----------------------------------------------------------------------------
module tb_seq_monitor;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE  = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] VAL = 4'd0;

    logic       lock_a, err_a;
    logic [7:0] err_cnt_a, lap_cnt_a;
    logic       lock_b, err_b;
    logic [1:0] err_cnt_b;
    logic [7:0] lap_cnt_b;
`ifdef SEQ_MONITOR_STICKY_EN
    logic       sticky_a, sticky_b;
`endif

    seq_monitor #(.LO(5), .HI(14), .ERR_W(8), .LAP_W(8)) dut_a (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .VAL(VAL),
        .LOCK(lock_a), .ERR(err_a), .ERR_CNT(err_cnt_a), .LAP_CNT(lap_cnt_a)
`ifdef SEQ_MONITOR_STICKY_EN
        , .ERR_STICKY(sticky_a)
`endif
    );

    seq_monitor #(.LO(5), .HI(14), .ERR_W(2), .LAP_W(8)) dut_b (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .VAL(VAL),
        .LOCK(lock_b), .ERR(err_b), .ERR_CNT(err_cnt_b), .LAP_CNT(lap_cnt_b)
`ifdef SEQ_MONITOR_STICKY_EN
        , .ERR_STICKY(sticky_b)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int err_pulses_b = 0;
    int val_r = 0;      // value the emulated counter presents after its next step

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_locked, m_prev, m_ce_d, m_err, m_nerr, m_lap, m_sticky;

    function automatic int succ(input int p);
        return (p == 5) ? 14 : p - 1;
    endfunction

    function automatic int legal(input int v);
        return (v >= 5 && v <= 14) ? 1 : 0;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_prev = 0; m_ce_d = 0; m_err = 0;
        m_nerr = 0; m_lap = 0; m_sticky = 0;
    endtask

    task automatic model_edge(input int ce, input int clr, input int v);
        if (clr != 0) begin
            model_reset();
        end else begin
            m_err = 0;
            if (m_ce_d != 0) begin
                if (m_locked == 0) begin
                    if (legal(v) != 0) begin
                        m_locked = 1;
                        m_prev = v;
                    end
                end else if (v == succ(m_prev)) begin
                    if (m_prev == 5) m_lap = (m_lap + 1) % 256;
                    m_prev = v;
                end else begin
                    m_err = 1;
                    m_nerr++;
                    m_sticky = 1;
                    if (legal(v) != 0) m_prev = v;
                    else m_locked = 0;
                end
            end
            m_ce_d = ce;
        end
    endtask

    task automatic check_all();
        chk("lock_a",    32'(lock_a),    32'(m_locked));
        chk("err_a",     32'(err_a),     32'(m_err));
        chk("err_cnt_a", 32'(err_cnt_a), 32'(sat(m_nerr, 255)));
        chk("lap_cnt_a", 32'(lap_cnt_a), 32'(m_lap));
        chk("lock_b",    32'(lock_b),    32'(m_locked));
        chk("err_b",     32'(err_b),     32'(m_err));
        chk("err_cnt_b", 32'(err_cnt_b), 32'(sat(m_nerr, 3)));
`ifdef SEQ_MONITOR_STICKY_EN
        chk("sticky_a",  32'(sticky_a),  32'(m_sticky));
        chk("sticky_b",  32'(sticky_b),  32'(m_sticky));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle. Inputs change on the falling edge, the model advances
    // on the rising edge, and outputs are compared 1 time unit later.
    task automatic tick(input int ce, input int clr);
        @(negedge CLK);
        CE  = (ce != 0);
        CLR = (clr != 0);
        VAL = 4'(val_r);
        @(posedge CLK);
        model_edge(ce, clr, val_r);
        #1;
        if (err_b === 1'b1) err_pulses_b++;
        check_all();
    endtask

    // Counter step: CE this cycle, new value visible from the next cycle.
    task automatic step(input int nv);
        tick(1, 0);
        val_r = nv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        CE = 1'b0; CLR = 1'b0; VAL = 4'd0; val_r = 0;
        RST = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        do_reset();

        // Legal run: 12 consecutive CE edges, 14..5,14,13.
        for (int i = 0; i < 12; i++) begin
            step(14 - (i % 10));
            if (i == 1) chk("legal_lock_n2", 32'(lock_a), 32'd1);
        end
        idle(3);
        chk("legal_errcnt", 32'(err_cnt_a), 32'd0);
        chk("legal_lap",    32'(lap_cnt_a), 32'd1);

        // Skip error: 10,9 then 7 (skips 8), then 6.
        tick(0, 1);
        step(10); idle(1); step(9); idle(1); step(7); idle(1);
        chk("skip_errcnt", 32'(err_cnt_a), 32'd1);
        chk("skip_lock",   32'(lock_a),    32'd1);
        step(6); idle(2);
        chk("skip_after",  32'(err_cnt_a), 32'd1);

        // Out of range: 7,6 then 2, then 14 re-acquires.
        tick(0, 1);
        step(7); idle(1); step(6); idle(1); step(2); idle(2);
        chk("oor_errcnt", 32'(err_cnt_a), 32'd1);
        chk("oor_lock",   32'(lock_a),    32'd0);
        step(14); idle(2);
        chk("oor_relock", 32'(lock_a),    32'd1);
        chk("oor_noerr",  32'(err_cnt_a), 32'd1);

        // Saturation and stall: lock at 9, 8, then 8 held for 5 CE steps.
        tick(0, 1);
        step(9); idle(1); step(8); idle(1);
        err_pulses_b = 0;
        for (int i = 0; i < 5; i++) begin
            step(8); idle(1);
        end
        idle(1);
        chk("sat_pulses", 32'(err_pulses_b), 32'd5);
        chk("sat_cnt_w2", 32'(err_cnt_b),    32'd3);
        chk("sat_cnt_w8", 32'(err_cnt_a),    32'd5);

        // CLR on a sample cycle: the sample of 12 is discarded.
        step(12);
        tick(0, 1);
        chk("clr_errcnt", 32'(err_cnt_a), 32'd0);
        chk("clr_lock",   32'(lock_a),    32'd0);
        idle(3);
        chk("clr_nolock", 32'(lock_a),    32'd0);

        // Async reset between edges, after building up lap and error state.
        step(7); idle(1); step(6); idle(1); step(5); idle(1); step(14); idle(1);
        step(11); idle(2);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("rst_lock",   32'(lock_a),    32'd0);
        chk("rst_err",    32'(err_a),     32'd0);
        chk("rst_errcnt", 32'(err_cnt_a), 32'd0);
        chk("rst_lap",    32'(lap_cnt_a), 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        step(7); idle(2);
        chk("rst_reacq",  32'(lock_a),    32'd1);
        chk("rst_noerr",  32'(err_cnt_a), 32'd0);

        // Sticky: one error, then a legal run, then CLR.
        tick(0, 1);
        step(10); idle(1); step(8); idle(1);
        for (int i = 0; i < 6; i++) begin
            step(succ(val_r)); idle(1);
        end
`ifdef SEQ_MONITOR_STICKY_EN
        chk("sticky_held", 32'(sticky_a), 32'd1);
`endif
        tick(0, 1);
`ifdef SEQ_MONITOR_STICKY_EN
        chk("sticky_clr",  32'(sticky_a), 32'd0);
`endif

        // Randomized phase.
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      step(legal(val_r) != 0 ? succ(val_r) : int'($urandom_range(5, 14)));
            else if (r < 70) step(int'($urandom_range(0, 15)));
            else if (r < 76) step(val_r);
            else if (r < 96) tick(0, 0);
            else             tick(int'($urandom_range(0, 1)), 1);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
